// File: rtl/mem_ctrl_pkg.sv
// ============================================================================
// Module  : mem_ctrl_pkg
// Brief   : Shared bus widths, access-length codes and FSM encodings for mem_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_ctrl_pkg;

    typedef logic [1:0]  mem_len_bus_t;
    typedef logic [7:0]  ram_bus_t;
    typedef logic [31:0] reg_bus_t;
    typedef logic [31:0] inst_addr_bus_t;

    localparam logic     RstEnable = 1'b1;
    localparam reg_bus_t ZeroWord  = 32'h0000_0000;

    localparam mem_len_bus_t MEM_LEN_B = 2'd0;
    localparam mem_len_bus_t MEM_LEN_H = 2'd1;
    localparam mem_len_bus_t MEM_LEN_W = 2'd2;

    localparam logic [1:0] MC_IDLE  = 2'd0;
    localparam logic [1:0] MC_READ  = 2'd1;
    localparam logic [1:0] MC_WRITE = 2'd2;
    localparam logic [1:0] MC_DONE  = 2'd3;

    // The unused encoding 3 is treated as a full word.
    function automatic logic [2:0] len_bytes(input mem_len_bus_t len);
        case (len)
            MEM_LEN_B: return 3'd1;
            MEM_LEN_H: return 3'd2;
            MEM_LEN_W: return 3'd4;
            default:   return 3'd4;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_ctrl.sv
// ============================================================================
// Module  : mem_ctrl
// Brief   : IF/MEM arbiter serialising word/half/byte accesses onto an 8-bit
//           RAM bus. Define MEM_CTRL_FAIR_EN for alternating-priority arbitration.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           if_req,
    input  inst_addr_bus_t if_addr,
    input  logic           if_flush,
    output logic           if_done,
    output reg_bus_t       if_data,
    input  logic           mem_req,
    input  logic           mem_we,
    input  mem_len_bus_t   mem_len,
    input  reg_bus_t       mem_addr,
    input  reg_bus_t       mem_wdata,
    output logic           mem_done,
    output reg_bus_t       mem_rdata,
    output reg_bus_t       ram_addr,
    output logic           ram_wr,
    output ram_bus_t       ram_dout,
    input  ram_bus_t       ram_din,
    output logic           stallreq_if,
    output logic           stallreq_mem
);

    logic [1:0] r_state;
    logic       r_owner_mem;
    logic [2:0] r_nbytes;
    logic [2:0] r_cnt;
    reg_bus_t   r_wdata;
    reg_bus_t   r_buf;
    logic       w_grant_mem;
    logic       w_grant_if;

`ifdef MEM_CTRL_FAIR_EN
    // 1 = MEM was granted last; resets to IF-last so MEM wins the first tie.
    logic r_last_mem;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_last_mem <= 1'b0;
        end else if (r_state == MC_IDLE && (w_grant_mem || w_grant_if)) begin
            r_last_mem <= w_grant_mem;
        end
    end

    assign w_grant_mem = mem_req & (~if_req | ~r_last_mem);
`else
    assign w_grant_mem = mem_req;
`endif
    assign w_grant_if  = if_req & ~w_grant_mem;

    // A flush landing in the done cycle still cancels the IF completion.
    assign if_done      = (r_state == MC_DONE) & ~r_owner_mem & ~if_flush;
    assign mem_done     = (r_state == MC_DONE) &  r_owner_mem;
    assign stallreq_if  = if_req  & ~if_done;
    assign stallreq_mem = mem_req & ~mem_done;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_state     <= MC_IDLE;
            r_owner_mem <= 1'b0;
            r_nbytes    <= 3'd0;
            r_cnt       <= 3'd0;
            r_wdata     <= ZeroWord;
            r_buf       <= ZeroWord;
            ram_addr    <= ZeroWord;
            ram_wr      <= 1'b0;
            ram_dout    <= 8'h00;
            if_data     <= ZeroWord;
            mem_rdata   <= ZeroWord;
        end else begin
            case (r_state)
                MC_IDLE: begin
                    ram_wr <= 1'b0;
                    r_cnt  <= 3'd0;
                    r_buf  <= ZeroWord;
                    if (w_grant_mem) begin
                        r_owner_mem <= 1'b1;
                        r_nbytes    <= len_bytes(mem_len);
                        ram_addr    <= mem_addr;
                        if (mem_we) begin
                            r_state  <= MC_WRITE;
                            ram_wr   <= 1'b1;
                            ram_dout <= mem_wdata[7:0];
                            r_wdata  <= {8'h00, mem_wdata[31:8]};
                        end else begin
                            r_state <= MC_READ;
                        end
                    end else if (w_grant_if) begin
                        r_owner_mem <= 1'b0;
                        r_nbytes    <= 3'd4;
                        ram_addr    <= if_addr;
                        r_state     <= MC_READ;
                    end
                end
                MC_READ: begin
                    // Byte r_cnt is on ram_din this cycle; one trailing cycle
                    // after the last capture before the result is published.
                    if (!r_owner_mem && if_flush) begin
                        r_state <= MC_IDLE;
                    end else if (r_cnt == r_nbytes) begin
                        r_state <= MC_DONE;
                        if (r_owner_mem) begin
                            mem_rdata <= r_buf;
                        end else begin
                            if_data <= r_buf;
                        end
                    end else begin
                        r_buf[{r_cnt[1:0], 3'b000} +: 8] <= ram_din;
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt != r_nbytes - 3'd1) begin
                            ram_addr <= ram_addr + 32'd1;
                        end
                    end
                end
                MC_WRITE: begin
                    if (r_cnt == r_nbytes - 3'd1) begin
                        ram_wr  <= 1'b0;
                        r_state <= MC_DONE;
                    end else begin
                        r_cnt    <= r_cnt + 3'd1;
                        ram_addr <= ram_addr + 32'd1;
                        ram_dout <= r_wdata[7:0];
                        r_wdata  <= {8'h00, r_wdata[31:8]};
                    end
                end
                MC_DONE: begin
                    r_state <= MC_IDLE;
                end
                default: begin
                    r_state <= MC_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// ============================================================================
// Module  : tb_mem_ctrl
// Brief   : Scoreboard bench for mem_ctrl with a byte-wide RAM model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_done;
    logic [31:0] if_addr, if_data;
    logic        mem_req, mem_we, mem_done;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic [7:0]  ram_dout, ram_din;
    logic        stallreq_if, stallreq_mem;

    mem_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_flush     (if_flush),
        .if_done      (if_done),
        .if_data      (if_data),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_len      (mem_len),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_done     (mem_done),
        .mem_rdata    (mem_rdata),
        .ram_addr     (ram_addr),
        .ram_wr       (ram_wr),
        .ram_dout     (ram_dout),
        .ram_din      (ram_din),
        .stallreq_if  (stallreq_if),
        .stallreq_mem (stallreq_mem)
    );

    always #5 clk = ~clk;

    // RAM model: read data follows the registered address, writes land on posedge.
    logic [7:0] ram [0:4095];
    logic       boot;

    assign ram_din = ram[ram_addr[11:0]];

    always @(posedge clk) begin
        if (boot) begin
            ram[12'h100] <= 8'h11;
            ram[12'h101] <= 8'h22;
            ram[12'h102] <= 8'h33;
            ram[12'h103] <= 8'h44;
            ram[12'h200] <= 8'h00;
            ram[12'h201] <= 8'h00;
            ram[12'h202] <= 8'h5A;
            ram[12'h300] <= 8'h80;
            ram[12'h400] <= 8'hEE;
            ram[12'h401] <= 8'hEE;
            ram[12'h402] <= 8'hEE;
            ram[12'h403] <= 8'hEE;
        end else if (ram_wr) begin
            ram[ram_addr[11:0]] <= ram_dout;
        end
    end

    typedef struct {
        bit          is_mem;
        bit          chk;
        logic [31:0] data;
    } done_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_exp_t;

    done_exp_t done_q[$];
    wr_exp_t   wr_q[$];

    int checks = 0;
    int errors = 0;
    int if_done_cnt = 0;
    int stall_bad;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: pops expectations whenever the DUT completes or writes a byte.
    done_exp_t md;
    wr_exp_t   mw;
    always @(negedge clk) begin
        if (if_done === 1'b1) if_done_cnt++;
        if (if_done === 1'b1 || mem_done === 1'b1) begin
            if (done_q.size() == 0) begin
                check("unexpected_done", {30'b0, if_done, mem_done}, 32'd0);
            end else begin
                md = done_q.pop_front();
                check("done_owner", {31'b0, mem_done}, {31'b0, md.is_mem});
                if (md.chk) check(md.is_mem ? "mem_rdata" : "if_data",
                                  md.is_mem ? mem_rdata : if_data, md.data);
            end
        end
        if (ram_wr === 1'b1) begin
            if (wr_q.size() == 0) begin
                check("unexpected_write", ram_addr, 32'hFFFF_FFFF);
            end else begin
                mw = wr_q.pop_front();
                check("wr_addr", ram_addr, mw.addr);
                check("wr_byte", {24'b0, ram_dout}, {24'b0, mw.data});
            end
        end
    end

    task automatic wait_done(input bit want_mem, input int budget, output int lat);
        bit seen = 1'b0;
        lat = 0;
        stall_bad = 0;
        while (!seen && lat < budget) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (want_mem ? mem_done : if_done) seen = 1'b1;
            else if (!(want_mem ? stallreq_mem : stallreq_if)) stall_bad++;
        end
        check("done_seen", {31'b0, seen}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ram_wr"},    {31'b0, ram_wr},   32'd0);
        check({tag, "_ram_addr"},  ram_addr,          32'd0);
        check({tag, "_ram_dout"},  {24'b0, ram_dout}, 32'd0);
        check({tag, "_if_done"},   {31'b0, if_done},  32'd0);
        check({tag, "_mem_done"},  {31'b0, mem_done}, 32'd0);
        check({tag, "_if_data"},   if_data,           32'd0);
        check({tag, "_mem_rdata"}, mem_rdata,         32'd0);
    endtask

    int lat;
    int cyc;
    int mcnt;
    int snap;

    initial begin
        boot = 1'b1; rst = 1'b1;
        if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h0; mem_wdata = 32'h0;
        repeat (3) @(negedge clk);
        boot = 1'b0;
        check_reset_outputs("reset");
        check("reset_stall_if", {31'b0, stallreq_if}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // IF word read
        if_req = 1'b1; if_addr = 32'h100;
        done_q.push_back('{is_mem: 1'b0, chk: 1'b1, data: 32'h4433_2211});
        wait_done(1'b0, 20, lat);
        check("if_latency", lat, 32'd6);
        check("if_stall_before_done", stall_bad, 32'd0);
        check("if_stall_at_done", {31'b0, stallreq_if}, 32'd0);
        if_req = 1'b0;
        @(negedge clk);
        check("if_done_one_cycle", {31'b0, if_done}, 32'd0);

        // MEM half store
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd1; mem_addr = 32'h200; mem_wdata = 32'hDEAD_ABCD;
        wr_q.push_back('{addr: 32'h200, data: 8'hCD});
        wr_q.push_back('{addr: 32'h201, data: 8'hAB});
        done_q.push_back('{is_mem: 1'b1, chk: 1'b0, data: 32'h0});
        wait_done(1'b1, 20, lat);
        check("half_store_latency", lat, 32'd3);
        mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        check("ram_200", {24'b0, ram[12'h200]}, 32'hCD);
        check("ram_201", {24'b0, ram[12'h201]}, 32'hAB);
        check("ram_202_untouched", {24'b0, ram[12'h202]}, 32'h5A);

        // MEM byte load
        mem_req = 1'b1; mem_len = 2'd0; mem_addr = 32'h300;
        done_q.push_back('{is_mem: 1'b1, chk: 1'b1, data: 32'h0000_0080});
        wait_done(1'b1, 20, lat);
        check("byte_load_latency", lat, 32'd3);
        mem_req = 1'b0;
        @(negedge clk);
        check("byte_load_hold", mem_rdata, 32'h0000_0080);

        // Simultaneous requests after reset; MEM keeps asking for two loads
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h100;
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h300;
        done_q.push_back('{is_mem: 1'b1, chk: 1'b1, data: 32'h0000_0080});
`ifdef MEM_CTRL_FAIR_EN
        done_q.push_back('{is_mem: 1'b0, chk: 1'b1, data: 32'h4433_2211});
        done_q.push_back('{is_mem: 1'b1, chk: 1'b1, data: 32'h0000_0080});
`else
        done_q.push_back('{is_mem: 1'b1, chk: 1'b1, data: 32'h0000_0080});
        done_q.push_back('{is_mem: 1'b0, chk: 1'b1, data: 32'h4433_2211});
`endif
        cyc = 0; mcnt = 0;
        while ((mcnt < 2 || if_req) && cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (mem_done) begin
                mcnt++;
                if (mcnt == 2) mem_req = 1'b0;
            end
            if (if_done) if_req = 1'b0;
        end
        check("arb_total_cycles", cyc, 32'd14);
        mem_req = 1'b0; if_req = 1'b0;
        @(negedge clk);

        // Flush one cycle after an IF grant, then a MEM load
        snap = if_done_cnt;
        if_req = 1'b1; if_addr = 32'h100;
        @(posedge clk);
        @(negedge clk);
        if_req = 1'b0; if_flush = 1'b1;
        mem_req = 1'b1; mem_len = 2'd0; mem_addr = 32'h300;
        done_q.push_back('{is_mem: 1'b1, chk: 1'b1, data: 32'h0000_0080});
        @(posedge clk);
        @(negedge clk);
        if_flush = 1'b0;
        wait_done(1'b1, 20, lat);
        check("flush_then_mem_latency", lat + 1, 32'd4);
        mem_req = 1'b0;
        @(negedge clk);
        check("flush_no_if_done", if_done_cnt - snap, 32'd0);

        // Reset in the middle of a word store
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2; mem_addr = 32'h400; mem_wdata = 32'h1122_3344;
        wr_q.push_back('{addr: 32'h400, data: 8'h44});
        wr_q.push_back('{addr: 32'h401, data: 8'h33});
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        check("midrst_ram_400", {24'b0, ram[12'h400]}, 32'h44);
        check("midrst_ram_401", {24'b0, ram[12'h401]}, 32'h33);
        check("midrst_ram_402", {24'b0, ram[12'h402]}, 32'hEE);
        check("midrst_ram_403", {24'b0, ram[12'h403]}, 32'hEE);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("done_q_drained", done_q.size(), 32'd0);
        check("wr_q_drained", wr_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_ctrl.md
# mem_ctrl

Single-port memory controller and arbiter between instruction fetch (IF) and the MEM stage. It serialises word, half and byte accesses onto an 8-bit RAM bus and reports per-requester stall requests to `ctrl`, which drives the stall bus seen by the pipeline registers. It sits between `if`/`mem` and the external RAM. It is the only agent that drives the RAM bus.

## Interface

Parameters:
- none. Widths come from `defines.v`.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset (`RstEnable` = 1'b1).
- `if_req`  in  1  IF read request; held until `if_done`.
- `if_addr`  in  32  IF word address.
- `if_flush`  in  1  discard the in-flight IF read (branch/jump taken).
- `if_done`  out  1  one-cycle pulse; `if_data` valid.
- `if_data`  out  32  fetched instruction.
- `mem_req`  in  1  MEM request; held until `mem_done`.
- `mem_we`  in  1  1 = store, 0 = load.
- `mem_len`  in  2  `MEM_LEN_B`=0, `MEM_LEN_H`=1, `MEM_LEN_W`=2 (1/2/4 bytes).
- `mem_addr`  in  32  byte address.
- `mem_wdata`  in  32  store data; low `len` bytes used.
- `mem_done`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  32  load data, zero-extended. Sign extension is done in `mem`.
- `ram_addr`  out  32  RAM byte address (registered).
- `ram_wr`  out  1  RAM write strobe (registered).
- `ram_dout`  out  8  RAM write byte (registered).
- `ram_din`  in  8  RAM read byte. Valid one cycle after its `ram_addr`.
- `stallreq_if`  out  1  `if_req & ~if_done` (combinational).
- `stallreq_mem`  out  1  `mem_req & ~mem_done` (combinational).

## Operation

- FSM states: `IDLE`, `READ`, `WRITE`, `DONE`.
- Grant happens only in `IDLE`.
  - MEM has priority over IF.
  - There is no preemption.
  - On grant, latch owner, address, length N (1/2/4; IF always 4), write data and direction.
- `READ`:
  - Drive `ram_addr` = base+0 … base+N-1 on consecutive cycles.
  - Capture byte i from `ram_din` one cycle after its address into bits [8i+7:8i] (little-endian).
  - Unused upper bytes read as 0.
- `WRITE`:
  - Drive `ram_wr`=1 with `ram_addr`=base+i and `ram_dout`=wdata[8i+7:8i] for i = 0..N-1.
  - Then drop `ram_wr`.
- `DONE`:
  - Pulse the owner's done for one cycle. Data outputs hold until the next grant.
  - `req` is ignored this cycle.
  - Go to `IDLE`.
- Flush:
  - `if_flush` while the IF read is in `READ` → next edge to `IDLE`. Captured bytes are discarded and no `if_done` is issued.
  - `if_flush` in `DONE` with IF as owner suppresses `if_done`.
  - `if_flush` never affects a MEM access.
- Idle bus: `ram_wr`=0, `ram_addr` holds its last value.
- Reset (any state, mid-access included) → next edge:
  - FSM is `IDLE`.
  - `ram_wr`=0, `ram_addr`=`ZeroWord`, `ram_dout`=0.
  - `if_done`=`mem_done`=0, `if_data`=`mem_rdata`=`ZeroWord`.
  - An interrupted write is left partially done; no rollback.

## Timing

- A request is granted at edge k (FSM in `IDLE`, `req` high). The first `ram_addr` is visible after edge k.
- Read of N bytes: last byte captured at edge k+N. Done is high in the cycle after edge k+N+1.
  - Word read: done after edge k+5.
- Write of N bytes: `ram_wr` high for cycles after edges k..k+N-1. Done is high after edge k+N.
- Earliest next grant: the edge ending the done cycle + 1, i.e. one idle cycle between accesses.
- Stall requests are combinational. They fall in the same cycle that done rises.

## Configuration

- `MEM_CTRL_FAIR_EN` defined:
  - A 1-bit `last_owner` register is kept.
  - When both requests are pending in `IDLE`, the requester that was not granted last wins.
  - Reset value is IF-last, so MEM wins first.
- Undefined: fixed MEM-over-IF priority. No `last_owner` register.

## Structure

- Add to `defines.v`:
  - `MemLenBus` (1:0) and `MEM_LEN_B/H/W`.
  - `RamBus` (7:0).
  - FSM state encodings `MC_IDLE/READ/WRITE/DONE`.
- Reuse `RstEnable`, `ZeroWord`, `RegBus`, `InstAddrBus`.
- Single module. The byte counter and assembler are inline; no sub-module is warranted.

## Test plan

- IF read, `if_addr`=0x100, RAM[0x100..0x103]=11,22,33,44 → `if_data`=0x44332211; `if_done` high exactly one cycle, after edge k+5; `stallreq_if` high for the cycles after edges k-1..k+4.
- MEM half store, addr 0x200, wdata 0xDEADABCD → `ram_wr` two cycles: (0x200, CD), (0x201, AB); `mem_done` after edge k+2; RAM[0x202] unchanged.
- MEM byte load, addr 0x300, RAM=0x80 → `mem_rdata`=0x00000080 after edge k+3.
- `if_req` and `mem_req` both rise at edge k → MEM granted first, IF granted at the first idle edge after `mem_done`. With `MEM_CTRL_FAIR_EN`, repeated simultaneous requests alternate MEM, IF, MEM.
- `if_flush` one cycle after an IF grant → no `if_done`; FSM returns to `IDLE`; a following `mem_req` is granted at the next edge.
- `rst` asserted during the 3rd byte of a word store → next edge `ram_wr`=0, all outputs at reset values; only 2 RAM bytes written.
